// File: rtl/fdiv_fsqrt_rs_pkg.sv
// Shared types and FP32 arithmetic helpers for the fdiv/fsqrt reservation station.
// Covers normal operands only; results round to nearest-even.
`default_nettype none

package fdiv_fsqrt_rs_pkg;

  localparam int ROB_WIDTH    = 5;
  localparam int CORE_LATENCY = 3;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  typedef enum logic {
    OP_FDIV  = 1'b0,
    OP_FSQRT = 1'b1
  } fdiv_or_fsqrt_t;

  typedef struct packed {
    logic                      valid;
    fdiv_or_fsqrt_t            op;
    logic [ROB_WIDTH-1:0]      tag;
    logic [1:0]                opd_valid;
    logic [1:0][ROB_WIDTH-1:0] opd_tag;
    logic [1:0][31:0]          opd_data;
  } fdiv_fsqrt_entry_t;

  localparam fdiv_fsqrt_entry_t e_invalid = '{
    valid: 1'b0, op: OP_FDIV, tag: '0, opd_valid: '0, opd_tag: '0, opd_data: '0
  };

  function automatic fdiv_fsqrt_entry_t wakeup(input fdiv_fsqrt_entry_t e, input cdb_t c);
    fdiv_fsqrt_entry_t r;
    r = e;
    for (int j = 0; j < 2; j++) begin
      if (!e.opd_valid[j] && c.valid && (c.tag == e.opd_tag[j])) begin
        r.opd_valid[j] = 1'b1;
        r.opd_data[j]  = c.data;
      end
    end
    return r;
  endfunction

  // mant carries the hidden bit in [23]; it is folded into the exponent field by the add.
  function automatic logic [31:0] round_pack(input logic sign, input logic signed [11:0] exp,
                                             input logic [23:0] mant, input logic guard,
                                             input logic sticky);
    logic [24:0]        m;
    logic signed [11:0] e;
    m = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    e = exp;
    if (m[24]) begin
      m = m >> 1;
      e = e + 12'sd1;
    end
    if (e >= 12'sd255) return {sign, 8'hFF, 23'd0};
    if (e <= 12'sd0)   return {sign, 31'd0};
    return {sign, ({8'(e - 12'sd1), 23'd0} + {7'd0, m[23:0]})};
  endfunction

  function automatic logic [31:0] fdiv_f32(input logic [31:0] a, input logic [31:0] b);
    logic               sign;
    logic [49:0]        num;
    logic [49:0]        div;
    logic [26:0]        q;
    logic               rem_nz;
    logic signed [11:0] e;
    sign = a[31] ^ b[31];
    if (a[30:23] == 8'd0) return {sign, 31'd0};
    if (b[30:23] == 8'd0) return {sign, 8'hFF, 23'd0};
    num    = {1'b1, a[22:0], 26'd0};
    div    = {26'd0, 1'b1, b[22:0]};
    q      = 27'(num / div);
    rem_nz = (num % div) != 50'd0;
    e      = $signed({4'd0, a[30:23]}) - $signed({4'd0, b[30:23]}) + 12'sd127;
    if (q[26]) return round_pack(sign, e, q[26:3], q[2], (|q[1:0]) | rem_nz);
    return round_pack(sign, e - 12'sd1, q[25:2], q[1], q[0] | rem_nz);
  endfunction

  function automatic logic [31:0] fsqrt_f32(input logic [31:0] a);
    logic signed [11:0] ue;
    logic signed [11:0] ue_even;
    logic [49:0]        rad;
    logic [49:0]        t;
    logic [24:0]        r;
    logic               odd;
    if (a[30:23] == 8'd0) return {a[31], 31'd0};
    if (a[31])            return 32'h7FC0_0000;
    ue      = $signed({4'd0, a[30:23]}) - 12'sd127;
    odd     = ue[0];
    ue_even = odd ? (ue - 12'sd1) : ue;
    rad     = odd ? {1'b1, a[22:0], 26'd0} : {2'b01, a[22:0], 25'd0};
    r       = '0;
    for (int i = 24; i >= 0; i--) begin
      t = {25'd0, r} | (50'd1 << i);
      if ((t * t) <= rad) r = t[24:0];
    end
    t = {25'd0, r};
    return round_pack(1'b0, (ue_even >>> 1) + 12'sd127, r[24:1], r[0], (t * t) != rad);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fdiv_fsqrt_rs_oldest_ready.sv
// rs_oldest_ready: lowest-index ready entry; index 0 reported when nothing is ready.
`default_nettype none

module rs_oldest_ready
  import fdiv_fsqrt_rs_pkg::*;
#(
  parameter int N_ENTRY = 4
) (
  input  logic [N_ENTRY-1:0]         ready,
  output logic [$clog2(N_ENTRY)-1:0] idx,
  output logic                       found
);

  localparam int IW = $clog2(N_ENTRY);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N_ENTRY - 1; i >= 0; i--) begin
      if (ready[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fdiv_fsqrt_rs.sv
// fdiv_fsqrt_rs: age-ordered reservation station feeding the fdiv/fsqrt cores.
// FDIV_FSQRT_ISSUE_BYPASS_EN: capture a same-cycle CDB broadcast for operands issued invalid.
`default_nettype none

module fdiv_fsqrt_rs
  import fdiv_fsqrt_rs_pkg::*;
#(
  parameter int N_ENTRY = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic                           issue_is_fsqrt,
  input  logic [ROB_WIDTH-1:0]           issue_tag,
  input  cdb_t [1:0]                     fpr_read,
  input  cdb_t                           fpr_cdb,
  output logic                           cdb_req_valid,
  input  logic                           cdb_req_ready,
  output logic                           cdb_req_is_fsqrt,
  output logic [ROB_WIDTH-1:0]           tag,
  output logic [31:0]                    result_fdiv,
  output logic [31:0]                    result_fsqrt,
  output logic [$clog2(N_ENTRY+1)-1:0]   n_valid
);

  localparam int IW = $clog2(N_ENTRY);
  localparam int CW = $clog2(N_ENTRY + 1);

  fdiv_fsqrt_entry_t e_q     [N_ENTRY];
  fdiv_fsqrt_entry_t e_d     [N_ENTRY];
  fdiv_fsqrt_entry_t woken   [N_ENTRY];
  fdiv_fsqrt_entry_t shifted [N_ENTRY];
  fdiv_fsqrt_entry_t cand;
  fdiv_fsqrt_entry_t new_entry;

  logic [CW-1:0]      n_valid_q, n_valid_d, n_after;
  logic [N_ENTRY-1:0] ready;
  logic [IW-1:0]      cand_idx;
  logic               cand_found;
  logic               dispatch;
  logic               issue_fire;

  logic [31:0] fdiv_pipe_q  [CORE_LATENCY];
  logic [31:0] fdiv_pipe_d  [CORE_LATENCY];
  logic [31:0] fsqrt_pipe_q [CORE_LATENCY];
  logic [31:0] fsqrt_pipe_d [CORE_LATENCY];

  for (genvar i = 0; i < N_ENTRY; i++) begin : g_entry
    assign ready[i] = e_q[i].valid & (&e_q[i].opd_valid);
    assign woken[i] = wakeup(e_q[i], fpr_cdb);
    if (i < N_ENTRY - 1) begin : g_mid
      assign shifted[i] = woken[i+1];
    end else begin : g_top
      assign shifted[i] = e_invalid;
    end
  end

  rs_oldest_ready #(.N_ENTRY(N_ENTRY)) u_oldest_ready (
    .ready (ready),
    .idx   (cand_idx),
    .found (cand_found)
  );

  assign cand             = e_q[cand_idx];
  assign cdb_req_valid    = cand_found;
  assign cdb_req_is_fsqrt = (cand.op == OP_FSQRT);
  assign tag              = cand.tag;
  assign dispatch         = cand_found & cdb_req_ready;
  assign issue_ready      = dispatch | ~e_q[N_ENTRY-1].valid;
  assign issue_fire       = issue_valid & issue_ready;
  assign n_valid          = n_valid_q;

  always_comb begin
    new_entry       = e_invalid;
    new_entry.valid = 1'b1;
    new_entry.op    = issue_is_fsqrt ? OP_FSQRT : OP_FDIV;
    new_entry.tag   = issue_tag;
    for (int j = 0; j < 2; j++) begin
      new_entry.opd_valid[j] = fpr_read[j].valid;
      new_entry.opd_tag[j]   = fpr_read[j].tag;
      new_entry.opd_data[j]  = fpr_read[j].data;
`ifdef FDIV_FSQRT_ISSUE_BYPASS_EN
      if (!fpr_read[j].valid && fpr_cdb.valid && (fpr_cdb.tag == fpr_read[j].tag)) begin
        new_entry.opd_valid[j] = 1'b1;
        new_entry.opd_data[j]  = fpr_cdb.data;
      end
`endif
    end
    // fsqrt has a single source; the second slot never gates dispatch.
    if (issue_is_fsqrt) new_entry.opd_valid[1] = 1'b1;
  end

  always_comb begin
    n_after   = n_valid_q - CW'(dispatch);
    n_valid_d = n_after + CW'(issue_fire);
    for (int i = 0; i < N_ENTRY; i++) begin
      e_d[i] = (dispatch && (IW'(i) >= cand_idx)) ? shifted[i] : woken[i];
      if (issue_fire && (n_after == CW'(i))) e_d[i] = new_entry;
    end
  end

  always_comb begin
    fdiv_pipe_d[0]  = fdiv_f32(cand.opd_data[0], cand.opd_data[1]);
    fsqrt_pipe_d[0] = fsqrt_f32(cand.opd_data[0]);
    for (int i = 1; i < CORE_LATENCY; i++) begin
      fdiv_pipe_d[i]  = fdiv_pipe_q[i-1];
      fsqrt_pipe_d[i] = fsqrt_pipe_q[i-1];
    end
  end

  assign result_fdiv  = fdiv_pipe_q[CORE_LATENCY-1];
  assign result_fsqrt = fsqrt_pipe_q[CORE_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRY; i++) e_q[i] <= e_invalid;
      n_valid_q <= '0;
    end else begin
      e_q       <= e_d;
      n_valid_q <= n_valid_d;
    end
  end

  // Core pipelines free-run; the arbiter only consumes slots it dispatched.
  always_ff @(posedge clk) begin
    fdiv_pipe_q  <= fdiv_pipe_d;
    fsqrt_pipe_q <= fsqrt_pipe_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_fdiv_fsqrt_rs.sv
// Self-checking bench for fdiv_fsqrt_rs: directed tables, corner sequences, random traffic.
`default_nettype none

module tb_fdiv_fsqrt_rs;
  import fdiv_fsqrt_rs_pkg::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 reset, issue_valid, issue_is_fsqrt, cdb_req_ready;
  logic [ROB_WIDTH-1:0] issue_tag, tag;
  cdb_t [1:0]           fpr_read;
  cdb_t                 fpr_cdb;
  logic                 issue_ready, cdb_req_valid, cdb_req_is_fsqrt;
  logic [31:0]          result_fdiv, result_fsqrt;
  logic [2:0]           n_valid;

  always #5 clk = ~clk;

  fdiv_fsqrt_rs #(.N_ENTRY(N)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_is_fsqrt(issue_is_fsqrt), .issue_tag(issue_tag), .fpr_read(fpr_read),
    .fpr_cdb(fpr_cdb), .cdb_req_valid(cdb_req_valid), .cdb_req_ready(cdb_req_ready),
    .cdb_req_is_fsqrt(cdb_req_is_fsqrt), .tag(tag), .result_fdiv(result_fdiv),
    .result_fsqrt(result_fsqrt), .n_valid(n_valid)
  );

  typedef struct {
    bit               fsqrt;
    logic [4:0]       tag;
    bit [1:0]         v;
    logic [1:0][4:0]  t;
    logic [1:0][31:0] d;
  } m_entry_t;

  typedef struct {
    int          due;
    bit          fsqrt;
    logic [31:0] res;
  } pend_t;

  typedef struct {
    bit         iv;
    logic [4:0] itag;
    cdb_t       r0;
    cdb_t       cb;
    bit         rdy;
    bit         e_cv;
    logic [4:0] e_tag;
    bit         e_ir;
    int         e_n;
  } vec_t;

  m_entry_t mq[$];
  pend_t    pq[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  int       edge_cnt = 0;
  cdb_t     NONE;

  function automatic cdb_t mk(input bit v, input logic [4:0] t, input logic [31:0] d);
    cdb_t c;
    c.valid = v; c.tag = t; c.data = d;
    return c;
  endfunction

  function automatic real f2d(input logic [31:0] f);
    logic [63:0] b;
    b = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] d2f(input real x);
    logic [63:0] b;
    logic [24:0] m;
    int          e;
    b = $realtobits(x);
    e = int'(b[62:52]) - 896;
    m = {2'b01, b[51:29]};
    if (b[28] && ((|b[27:0]) || b[29])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e++; end
    if (e >= 255) return {b[63], 8'hFF, 23'd0};
    if (e <= 0)   return {b[63], 31'd0};
    return {b[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_f();
    return {1'b0, 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input bit iv, input bit fs, input logic [4:0] itg, input cdb_t r0,
                       input cdb_t r1, input cdb_t cb, input bit rdy);
    reset = 1'b0; issue_valid = iv; issue_is_fsqrt = fs; issue_tag = itg;
    fpr_read[0] = r0; fpr_read[1] = r1; fpr_cdb = cb; cdb_req_ready = rdy;
    #2;
  endtask

  // Compare against the queue model, clock once, advance the model.
  task automatic clock_model();
    int       ci;
    bit       disp, ir;
    m_entry_t ne;
    pend_t    p;
    ci = -1;
    for (int i = 0; i < mq.size(); i++) if (ci < 0 && mq[i].v == 2'b11) ci = i;
    disp = (ci >= 0) && cdb_req_ready;
    ir   = disp || (mq.size() < N);
    chk("cdb_req_valid", cdb_req_valid, (ci >= 0));
    if (ci >= 0) begin
      chk("tag", tag, mq[ci].tag);
      chk("cdb_req_is_fsqrt", cdb_req_is_fsqrt, mq[ci].fsqrt);
    end
    chk("issue_ready", issue_ready, ir);
    chk("n_valid", n_valid, mq.size());
    if (disp) begin
      p.due   = edge_cnt + CORE_LATENCY;
      p.fsqrt = mq[ci].fsqrt;
      p.res   = mq[ci].fsqrt ? d2f($sqrt(f2d(mq[ci].d[0])))
                             : d2f(f2d(mq[ci].d[0]) / f2d(mq[ci].d[1]));
      pq.push_back(p);
    end
    ne.fsqrt = issue_is_fsqrt;
    ne.tag   = issue_tag;
    for (int j = 0; j < 2; j++) begin
      ne.v[j] = fpr_read[j].valid;
      ne.t[j] = fpr_read[j].tag;
      ne.d[j] = fpr_read[j].data;
`ifdef FDIV_FSQRT_ISSUE_BYPASS_EN
      if (!ne.v[j] && fpr_cdb.valid && fpr_cdb.tag == ne.t[j]) begin
        ne.v[j] = 1'b1; ne.d[j] = fpr_cdb.data;
      end
`endif
    end
    if (issue_is_fsqrt) ne.v[1] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < mq.size(); i++)
      for (int j = 0; j < 2; j++)
        if (!mq[i].v[j] && fpr_cdb.valid && mq[i].t[j] == fpr_cdb.tag) begin
          mq[i].v[j] = 1'b1; mq[i].d[j] = fpr_cdb.data;
        end
    if (disp) mq.delete(ci);
    if (issue_valid && ir) mq.push_back(ne);
    edge_cnt++;
    #1;
    while (pq.size() > 0 && pq[0].due == edge_cnt) begin
      chk(pq[0].fsqrt ? "result_fsqrt" : "result_fdiv",
          pq[0].fsqrt ? result_fsqrt : result_fdiv, pq[0].res);
      void'(pq.pop_front());
    end
  endtask

  task automatic cyc(input bit iv, input bit fs, input logic [4:0] itg, input cdb_t r0,
                     input cdb_t r1, input cdb_t cb, input bit rdy);
    apply(iv, fs, itg, r0, r1, cb, rdy);
    clock_model();
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 1'b0, 5'd0, NONE, NONE, NONE, rdy);
  endtask

  task automatic do_reset(input bit iv);
    reset = 1'b1; issue_valid = iv; issue_is_fsqrt = 1'b0; issue_tag = 5'd31;
    fpr_read[0] = mk(1'b1, 5'd0, 32'h3F800000); fpr_read[1] = mk(1'b1, 5'd0, 32'h3F800000);
    fpr_cdb = NONE; cdb_req_ready = 1'b1;
    @(posedge clk);
    mq.delete(); pq.delete(); edge_cnt++;
    #1;
    reset = 1'b0; issue_valid = 1'b0;
    #1;
    chk("reset n_valid", n_valid, 0);
    chk("reset cdb_req_valid", cdb_req_valid, 0);
    chk("reset issue_ready", issue_ready, 1);
  endtask

  function automatic vec_t mkv(input bit iv, input logic [4:0] itag, input cdb_t r0,
                               input cdb_t cb, input bit rdy, input bit e_cv,
                               input logic [4:0] e_tag, input bit e_ir, input int e_n);
    vec_t v;
    v.iv = iv; v.itag = itag; v.r0 = r0; v.cb = cb; v.rdy = rdy;
    v.e_cv = e_cv; v.e_tag = e_tag; v.e_ir = e_ir; v.e_n = e_n;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[11];
    cdb_t w5, b2;
    NONE = mk(1'b0, 5'd0, 32'd0);
    w5   = mk(1'b0, 5'd5, 32'd0);
    b2   = mk(1'b1, 5'd0, 32'h40000000);
    reset = 1'b1; issue_valid = 1'b0; issue_is_fsqrt = 1'b0; issue_tag = '0;
    fpr_read = '0; fpr_cdb = NONE; cdb_req_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b0);

    // Single ready fdiv: 6.0 / 2.0
    cyc(1'b1, 1'b0, 5'd3, mk(1'b1, 5'd0, 32'h40C00000), b2, NONE, 1'b0);
    apply(1'b0, 1'b0, 5'd0, NONE, NONE, NONE, 1'b0);
    chk("s1 cdb_req_valid", cdb_req_valid, 1);
    chk("s1 tag", tag, 3);
    chk("s1 is_fsqrt", cdb_req_is_fsqrt, 0);
    clock_model();
    idle(1'b1);
    repeat (CORE_LATENCY - 1) idle(1'b1);
    chk("s1 result_fdiv", result_fdiv, 32'h40400000);

    // Four waiting on tag 5, one broadcast, in-order drain
    tbl[0]  = mkv(1, 5'd1, w5, NONE, 1, 0, 0, 1, 0);
    tbl[1]  = mkv(1, 5'd2, w5, NONE, 1, 0, 0, 1, 1);
    tbl[2]  = mkv(1, 5'd3, w5, NONE, 1, 0, 0, 1, 2);
    tbl[3]  = mkv(1, 5'd4, w5, NONE, 1, 0, 0, 1, 3);
    tbl[4]  = mkv(0, 5'd0, NONE, mk(1, 5'd5, 32'h40C00000), 1, 0, 0, 0, 4);
    tbl[5]  = mkv(0, 5'd0, NONE, NONE, 0, 1, 5'd1, 0, 4);
    tbl[6]  = mkv(0, 5'd0, NONE, NONE, 1, 1, 5'd1, 1, 4);
    tbl[7]  = mkv(0, 5'd0, NONE, NONE, 1, 1, 5'd2, 1, 3);
    tbl[8]  = mkv(0, 5'd0, NONE, NONE, 1, 1, 5'd3, 1, 2);
    tbl[9]  = mkv(0, 5'd0, NONE, NONE, 1, 1, 5'd4, 1, 1);
    tbl[10] = mkv(0, 5'd0, NONE, NONE, 1, 0, 0, 1, 0);
    do_reset(1'b0);
    for (int k = 0; k < 11; k++) begin
      apply(tbl[k].iv, 1'b0, tbl[k].itag, tbl[k].r0, b2, tbl[k].cb, tbl[k].rdy);
      chk($sformatf("tbl%0d cdb_req_valid", k), cdb_req_valid, tbl[k].e_cv);
      if (tbl[k].e_cv) chk($sformatf("tbl%0d tag", k), tag, tbl[k].e_tag);
      chk($sformatf("tbl%0d issue_ready", k), issue_ready, tbl[k].e_ir);
      chk($sformatf("tbl%0d n_valid", k), n_valid, tbl[k].e_n);
      clock_model();
    end
    repeat (CORE_LATENCY) idle(1'b1);

    // Younger ready fsqrt overtakes waiting entry0
    do_reset(1'b0);
    cyc(1'b1, 1'b0, 5'd2, mk(1'b0, 5'd6, 32'd0), b2, NONE, 1'b0);
    cyc(1'b1, 1'b1, 5'd9, mk(1'b1, 5'd0, 32'h41100000), NONE, NONE, 1'b0);
    apply(1'b0, 1'b0, 5'd0, NONE, NONE, NONE, 1'b1);
    chk("s3 tag", tag, 9);
    chk("s3 is_fsqrt", cdb_req_is_fsqrt, 1);
    clock_model();
    repeat (CORE_LATENCY - 1) idle(1'b1);
    chk("s3 result_fsqrt", result_fsqrt, 32'h40400000);
    chk("s3 n_valid", n_valid, 1);
    cyc(1'b0, 1'b0, 5'd0, NONE, NONE, mk(1'b1, 5'd6, 32'h41000000), 1'b0);
    apply(1'b0, 1'b0, 5'd0, NONE, NONE, NONE, 1'b1);
    chk("s3 entry0 tag", tag, 2);
    clock_model();
    repeat (CORE_LATENCY) idle(1'b1);

    // Full station: dispatch and issue in the same cycle
    do_reset(1'b0);
    cyc(1'b1, 1'b0, 5'd10, mk(1'b1, 5'd0, 32'h40C00000), b2, NONE, 1'b0);
    for (int k = 11; k <= 13; k++) cyc(1'b1, 1'b0, 5'(k), mk(1'b0, 5'd20, 32'd0), b2, NONE, 1'b0);
    apply(1'b1, 1'b0, 5'd14, mk(1'b1, 5'd0, 32'h41100000), mk(1'b1, 5'd0, 32'h40400000), NONE, 1'b1);
    chk("s4 issue_ready", issue_ready, 1);
    chk("s4 tag", tag, 10);
    clock_model();
    apply(1'b0, 1'b0, 5'd0, NONE, NONE, NONE, 1'b0);
    chk("s4 n_valid", n_valid, 4);
    chk("s4 new tag", tag, 14);
    clock_model();
    cyc(1'b0, 1'b0, 5'd0, NONE, NONE, mk(1'b1, 5'd20, 32'h40800000), 1'b0);
    for (int k = 11; k <= 14; k++) begin
      apply(1'b0, 1'b0, 5'd0, NONE, NONE, NONE, 1'b1);
      chk("s4 drain tag", tag, k);
      clock_model();
    end
    repeat (CORE_LATENCY) idle(1'b1);

    // Issue racing a same-cycle broadcast of its source tag
    do_reset(1'b0);
    cyc(1'b1, 1'b0, 5'd8, mk(1'b0, 5'd7, 32'd0), b2, mk(1'b1, 5'd7, 32'h3F800000), 1'b0);
    apply(1'b0, 1'b0, 5'd0, NONE, NONE, NONE, 1'b0);
`ifdef FDIV_FSQRT_ISSUE_BYPASS_EN
    chk("s5 bypass cdb_req_valid", cdb_req_valid, 1);
`else
    chk("s5 nobypass cdb_req_valid", cdb_req_valid, 0);
`endif
    clock_model();
    cyc(1'b0, 1'b0, 5'd0, NONE, NONE, mk(1'b1, 5'd7, 32'h40800000), 1'b0);
    apply(1'b0, 1'b0, 5'd0, NONE, NONE, NONE, 1'b1);
    chk("s5 late cdb_req_valid", cdb_req_valid, 1);
    clock_model();
    repeat (CORE_LATENCY) idle(1'b1);

    // Reset with entries held and an issue pending
    do_reset(1'b0);
    for (int k = 1; k <= 3; k++) cyc(1'b1, 1'b0, 5'(k), mk(1'b0, 5'd30, 32'd0), b2, NONE, 1'b0);
    do_reset(1'b1);

    // Random traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset(1'b1);
      end else begin
        cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)),
            mk($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), rnd_f()),
            mk($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), rnd_f()),
            mk($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), rnd_f()),
            $urandom_range(0, 3) != 0);
      end
    end
    repeat (CORE_LATENCY + 2) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
